// File: rtl/tx_frame_striper.sv
// TX framing and lane striping: wraps link-layer bytes in STP/END, buffers them
// as symbols and emits one symbol per lane per pclk, nullifying starved packets with EDB.
module tx_frame_striper #(
  parameter int LANES     = 4,
  parameter int BYTES_IN  = 8,
  parameter int SYM_DEPTH = 64
) (
  input  logic                           pclk,
  input  logic                           reset_n,
  input  logic                           tx_en,
  input  logic                           lp_irdy,
  output logic                           pl_trdy,
  input  logic [8*BYTES_IN-1:0]          lp_data,
  input  logic [BYTES_IN-1:0]            lp_valid,
  input  logic [BYTES_IN-1:0]            lp_tlpstart,
  input  logic [BYTES_IN-1:0]            lp_tlpend,
  output logic [8*LANES-1:0]             tx_data,
  output logic [LANES-1:0]               tx_datak,
  output logic                           tx_valid,
  output logic                           underrun_err,
  output logic [$clog2(SYM_DEPTH+1)-1:0] sym_count
);

  localparam int PW   = $clog2(SYM_DEPTH);
  localparam int CW   = $clog2(SYM_DEPTH + 1);
  localparam int LW   = $clog2(LANES + 1);
  localparam int MAXW = 3 * BYTES_IN;
  localparam int WW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] LANES_OCC  = CW'(LANES);
  localparam logic [LW-1:0] LANES_CNT  = LW'(LANES);
  localparam logic [CW-1:0] TRDY_LIMIT = CW'(SYM_DEPTH - MAXW);

  typedef struct packed {
    logic       k;
    logic [7:0] d;
  } sym_t;

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  localparam sym_t STP_SYM  = '{k: 1'b1, d: 8'hFB};
  localparam sym_t END_SYM  = '{k: 1'b1, d: 8'hFD};
  localparam sym_t PAD_SYM  = '{k: 1'b1, d: 8'hF7};
  localparam sym_t EDB_SYM  = '{k: 1'b1, d: 8'hFE};
  localparam sym_t IDLE_SYM = '{k: 1'b0, d: 8'h00};

  function automatic logic isStp(input sym_t s);
    return s == STP_SYM;
  endfunction

  function automatic logic isEnd(input sym_t s);
    return s == END_SYM;
  endfunction

  sym_t           mem [SYM_DEPTH];
  logic [PW-1:0]  wrPtr, rdPtr;
  logic [CW-1:0]  occ, occNext, wrAdd;
  state_t         state, nextState;

  sym_t           wrSyms [MAXW];
  logic [WW-1:0]  wrCount;
  logic           accept;

  sym_t           peek [LANES];
  sym_t           outWord [LANES];
  logic [LW-1:0]  avail, popCnt;
  logic           underrunPulse;
  logic           trdyNext;

  assign accept    = lp_irdy && pl_trdy && tx_en;
  assign sym_count = occ;

  // Expand each valid byte into STP?/byte/END? symbols, packed in byte order.
  always_comb begin
    int idx;
    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    idx = 0;
    for (int k = 0; k < MAXW; k++) wrSyms[k] = IDLE_SYM;
    for (int i = 0; i < BYTES_IN; i++) begin
      if (lp_valid[i]) begin
        if (lp_tlpstart[i]) begin
          wrSyms[idx] = STP_SYM;
          idx = idx + 1;
        end
        wrSyms[idx] = '{k: 1'b0, d: lp_data[8*i +: 8]};
        idx = idx + 1;
        if (lp_tlpend[i]) begin
          wrSyms[idx] = END_SYM;
          idx = idx + 1;
        end
      end
    end
    wrCount = WW'(idx);
  end

  // NOTE: the symbol store has no reset; pointers and occupancy alone decide which entries are live.
  always_ff @(posedge pclk) begin
    if (accept) begin
      for (int k = 0; k < MAXW; k++) begin
        if (k < int'(wrCount)) mem[wrPtr + PW'(k)] <= wrSyms[k];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) peek[l] = mem[rdPtr + PW'(l)];
  end

  assign avail = (occ >= LANES_OCC) ? LANES_CNT : LW'(occ);

  // Read side: the head window decides the next lane word, pops and state.
  always_comb begin
    logic endSeen;
    logic endInWin;
    logic buildWord;
    nextState     = state;
    popCnt        = '0;
    underrunPulse = 1'b0;
    endSeen       = 1'b0;
    endInWin      = 1'b0;
    buildWord     = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      outWord[l] = IDLE_SYM;
      if (l < int'(avail) && isEnd(peek[l])) endInWin = 1'b1;
    end

    unique case (state)
      IDLE: begin
        // A short packet whose END is already buffered may start below LANES symbols.
        if (avail != '0) begin
          if (isStp(peek[0])) begin
            if (occ >= LANES_OCC || endInWin) buildWord = 1'b1;
          end else begin
            popCnt = LW'(1);
          end
        end
      end
      PKT: buildWord = 1'b1;
      DROP: begin
        for (int l = 0; l < LANES; l++) begin
          if (!endSeen && l < int'(avail)) begin
            popCnt = LW'(l + 1);
            if (isEnd(peek[l])) endSeen = 1'b1;
          end
        end
        if (endSeen) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    if (buildWord) begin
      for (int l = 0; l < LANES; l++) begin
        if (endSeen) begin
          outWord[l] = PAD_SYM;
        end else if (l < int'(avail)) begin
          outWord[l] = peek[l];
          popCnt     = LW'(l + 1);
          if (isEnd(peek[l])) endSeen = 1'b1;
        end else begin
          outWord[l] = EDB_SYM;
        end
      end
      if (endSeen) begin
        nextState = IDLE;
      end else if (avail < LANES_CNT) begin
        nextState     = DROP;
        underrunPulse = 1'b1;
      end else begin
        nextState = PKT;
      end
    end
  end

  assign wrAdd    = accept ? CW'(wrCount) : '0;
  assign occNext  = occ + wrAdd - CW'(popCnt);
  assign trdyNext = tx_en && (occNext <= TRDY_LIMIT);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      occ          <= '0;
      state        <= IDLE;
      pl_trdy      <= 1'b0;
      tx_valid     <= 1'b0;
      underrun_err <= 1'b0;
      tx_data      <= '0;
      tx_datak     <= '0;
    end else if (!tx_en) begin
      // Leaving L0 flushes everything; an open packet is simply abandoned.
      wrPtr        <= '0;
      rdPtr        <= '0;
      occ          <= '0;
      state        <= IDLE;
      pl_trdy      <= 1'b0;
      tx_valid     <= 1'b0;
      underrun_err <= 1'b0;
      tx_data      <= '0;
      tx_datak     <= '0;
    end else begin
      if (accept) wrPtr <= wrPtr + PW'(wrCount);
      rdPtr        <= rdPtr + PW'(popCnt);
      occ          <= occNext;
      state        <= nextState;
      pl_trdy      <= trdyNext;
      tx_valid     <= 1'b1;
      underrun_err <= underrunPulse;
      for (int j = 0; j < LANES; j++) begin
        tx_data[8*j +: 8] <= outWord[j].d;
        tx_datak[j]       <= outWord[j].k;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_striper.sv
// Directed bench for tx_frame_striper (LANES=4, BYTES_IN=8, SYM_DEPTH=64):
// single-beat packet table plus underrun, backpressure and tx_en-drop sequences.
module tb_tx_frame_striper;

  localparam int LANES     = 4;
  localparam int BYTES_IN  = 8;
  localparam int SYM_DEPTH = 64;
  localparam int CW        = $clog2(SYM_DEPTH + 1);

  logic                   pclk = 1'b0;
  logic                   reset_n;
  logic                   tx_en;
  logic                   lp_irdy;
  logic                   pl_trdy;
  logic [8*BYTES_IN-1:0]  lp_data;
  logic [BYTES_IN-1:0]    lp_valid;
  logic [BYTES_IN-1:0]    lp_tlpstart;
  logic [BYTES_IN-1:0]    lp_tlpend;
  logic [8*LANES-1:0]     tx_data;
  logic [LANES-1:0]       tx_datak;
  logic                   tx_valid;
  logic                   underrun_err;
  logic [CW-1:0]          sym_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0]      data;
    logic [7:0]       valid;
    logic [7:0]       start;
    logic [7:0]       stop;
    int               nWords;
    logic [0:2][31:0] wData;
    logic [0:2][3:0]  wK;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] expQ [$];

  tx_frame_striper #(
    .LANES(LANES),
    .BYTES_IN(BYTES_IN),
    .SYM_DEPTH(SYM_DEPTH)
  ) dut (
    .pclk(pclk),
    .reset_n(reset_n),
    .tx_en(tx_en),
    .lp_irdy(lp_irdy),
    .pl_trdy(pl_trdy),
    .lp_data(lp_data),
    .lp_valid(lp_valid),
    .lp_tlpstart(lp_tlpstart),
    .lp_tlpend(lp_tlpend),
    .tx_data(tx_data),
    .tx_datak(tx_datak),
    .tx_valid(tx_valid),
    .underrun_err(underrun_err),
    .sym_count(sym_count)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clearBeat();
    lp_irdy     = 1'b0;
    lp_valid    = '0;
    lp_tlpstart = '0;
    lp_tlpend   = '0;
  endtask

  task automatic sendBeat(input logic [63:0] d, input logic [7:0] v, input logic [7:0] s,
                          input logic [7:0] e, input string name);
    lp_data     = d;
    lp_valid    = v;
    lp_tlpstart = s;
    lp_tlpend   = e;
    lp_irdy     = 1'b1;
    check({name, " trdy"}, 64'(pl_trdy), 64'd1);
    tick();
    clearBeat();
  endtask

  task automatic expectWord(input string name, input logic [31:0] d, input logic [3:0] k);
    tick();
    check({name, " data"}, 64'(tx_data), 64'(d));
    check({name, " datak"}, 64'(tx_datak), 64'(k));
    check({name, " underrun"}, 64'(underrun_err), 64'd0);
  endtask

  task automatic monitorStream();
    logic [7:0] b;
    if (tx_datak != 4'b0000) begin
      if (expQ.size() == 0) begin
        check("bp unexpected word", 64'(tx_data), 64'd0);
      end else begin
        b = expQ.pop_front();
        check("bp word data", 64'(tx_data), 64'({8'hF7, 8'hFD, b, 8'hFB}));
        check("bp word datak", 64'(tx_datak), 64'(4'b1101));
      end
    end else begin
      check("bp idle data", 64'(tx_data), 64'd0);
    end
  endtask

  initial begin
    logic acc;
    bit   sawStall;
    int   beat;

    reset_n = 1'b0;
    tx_en   = 1'b0;
    lp_data = '0;
    clearBeat();

    vecs[0] = '{64'h0807060504030201, 8'hFF, 8'h01, 8'h80, 3,
                {32'h030201FB, 32'h07060504, 32'hF7F7FD08}, {4'b0001, 4'b0000, 4'b1110}};
    vecs[1] = '{64'h00000000000000AA, 8'h01, 8'h01, 8'h01, 1,
                {32'hF7FDAAFB, 32'h0, 32'h0}, {4'b1101, 4'b0000, 4'b0000}};
    vecs[2] = '{64'h0000000000002211, 8'h03, 8'h01, 8'h02, 1,
                {32'hFD2211FB, 32'h0, 32'h0}, {4'b1001, 4'b0000, 4'b0000}};
    vecs[3] = '{64'h0000003534333231, 8'h1F, 8'h01, 8'h10, 2,
                {32'h333231FB, 32'hF7FD3534, 32'h0}, {4'b0001, 4'b1100, 4'b0000}};
    vecs[4] = '{64'h0000000000B2B1A1, 8'h07, 8'h03, 8'h05, 2,
                {32'hF7FDA1FB, 32'hFDB2B1FB, 32'h0}, {4'b1101, 4'b1001, 4'b0000}};
    vecs[5] = '{64'h0000000000006655, 8'h03, 8'h02, 8'h02, 2,
                {32'h00000000, 32'hF7FD66FB, 32'h0}, {4'b0000, 4'b1101, 4'b0000}};
    vecs[6] = '{64'h0000000000FD9977, 8'h01, 8'h03, 8'h09, 1,
                {32'hF7FD77FB, 32'h0, 32'h0}, {4'b1101, 4'b0000, 4'b0000}};
    vecs[7] = '{64'h00000000000000C7, 8'h00, 8'h01, 8'h01, 0,
                {32'h0, 32'h0, 32'h0}, {4'b0000, 4'b0000, 4'b0000}};

    tick();
    tick();
    check("reset trdy", 64'(pl_trdy), 64'd0);
    check("reset tx_valid", 64'(tx_valid), 64'd0);
    check("reset tx_data", 64'(tx_data), 64'd0);
    check("reset tx_datak", 64'(tx_datak), 64'd0);
    check("reset underrun", 64'(underrun_err), 64'd0);
    check("reset sym_count", 64'(sym_count), 64'd0);

    reset_n = 1'b1;
    tick();
    check("txen low trdy", 64'(pl_trdy), 64'd0);
    check("txen low tx_valid", 64'(tx_valid), 64'd0);
    tx_en = 1'b1;
    tick();
    check("txen up trdy", 64'(pl_trdy), 64'd1);
    check("txen up tx_valid", 64'(tx_valid), 64'd1);
    check("txen up idle data", 64'(tx_data), 64'd0);
    check("txen up idle datak", 64'(tx_datak), 64'd0);

    for (int n = 0; n < 8; n++) begin
      sendBeat(vecs[n].data, vecs[n].valid, vecs[n].start, vecs[n].stop, $sformatf("vec%0d", n));
      for (int w = 0; w < vecs[n].nWords; w++)
        expectWord($sformatf("vec%0d word%0d", n, w), vecs[n].wData[w], vecs[n].wK[w]);
      expectWord($sformatf("vec%0d idle", n), 32'h0, 4'h0);
      check($sformatf("vec%0d sym_count", n), 64'(sym_count), 64'd0);
    end

    // Starvation after four bytes of a ten-byte packet.
    sendBeat(64'h0000000043424140, 8'h0F, 8'h01, 8'h00, "under beat1");
    tick();
    check("under w0 data", 64'(tx_data), 64'h424140FB);
    check("under w0 datak", 64'(tx_datak), 64'(4'b0001));
    check("under w0 pulse", 64'(underrun_err), 64'd0);
    tick();
    check("under w1 data", 64'(tx_data), 64'hFEFEFE43);
    check("under w1 datak", 64'(tx_datak), 64'(4'b1110));
    check("under w1 pulse", 64'(underrun_err), 64'd1);
    tick();
    check("under w2 data", 64'(tx_data), 64'd0);
    check("under w2 pulse", 64'(underrun_err), 64'd0);
    tick();
    tick();
    sendBeat(64'h0000494847464544, 8'h3F, 8'h00, 8'h20, "under beat2");
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("drop c%0d data", c), 64'(tx_data), 64'd0);
      check($sformatf("drop c%0d datak", c), 64'(tx_datak), 64'd0);
      check($sformatf("drop c%0d pulse", c), 64'(underrun_err), 64'd0);
    end
    check("drop sym_count", 64'(sym_count), 64'd0);
    sendBeat(64'h00000000000000C3, 8'h01, 8'h01, 8'h01, "after drop");
    expectWord("after drop word", 32'hF7FDC3FB, 4'b1101);
    expectWord("after drop idle", 32'h0, 4'h0);

    // Continuous single-byte packets against backpressure.
    sawStall = 1'b0;
    beat     = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      lp_irdy     = 1'b1;
      lp_valid    = '1;
      lp_tlpstart = '1;
      lp_tlpend   = '1;
      for (int i = 0; i < BYTES_IN; i++) lp_data[8*i +: 8] = 8'(beat * 8 + i);
      acc = pl_trdy;
      tick();
      if (acc) begin
        for (int i = 0; i < BYTES_IN; i++) expQ.push_back(8'(beat * 8 + i));
        beat++;
      end else begin
        sawStall = 1'b1;
      end
      monitorStream();
      check("bp occupancy bound", 64'(sym_count <= 7'd64), 64'd1);
      check("bp trdy rule", 64'(pl_trdy), 64'(sym_count <= 7'd40));
    end
    clearBeat();
    for (int cyc = 0; cyc < 200 && expQ.size() > 0; cyc++) begin
      tick();
      monitorStream();
    end
    check("bp drained", 64'(expQ.size()), 64'd0);
    check("bp stall seen", 64'(sawStall), 64'd1);
    tick();
    check("bp final sym_count", 64'(sym_count), 64'd0);

    // Leave L0 in the middle of a packet.
    sendBeat(64'h1716151413121110, 8'hFF, 8'h01, 8'h00, "cut beat");
    expectWord("cut word0", 32'h121110FB, 4'b0001);
    tx_en = 1'b0;
    tick();
    check("cut sym_count", 64'(sym_count), 64'd0);
    check("cut trdy", 64'(pl_trdy), 64'd0);
    check("cut tx_valid", 64'(tx_valid), 64'd0);
    check("cut tx_data", 64'(tx_data), 64'd0);
    check("cut tx_datak", 64'(tx_datak), 64'd0);
    check("cut underrun", 64'(underrun_err), 64'd0);
    tick();
    tx_en = 1'b1;
    tick();
    check("rejoin trdy", 64'(pl_trdy), 64'd1);
    check("rejoin tx_valid", 64'(tx_valid), 64'd1);
    sendBeat(64'h0000000000000022, 8'h01, 8'h01, 8'h01, "rejoin");
    expectWord("rejoin word", 32'hF7FD22FB, 4'b1101);
    expectWord("rejoin idle", 32'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
